// File: rtl/axis_uart_pkg.sv
// Shared types and constants for the AXI-Stream UART blocks.
package axis_uart_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
endpackage

// File: rtl/axis_uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request strictly after 'last', wrapping around.
module rr_priority_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 any_req,
  output logic [$clog2(N)-1:0] pick
);
  localparam int LW = $clog2(N);

  logic [LW-1:0]  w_start;
  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [LW:0]    w_sum;

  // Rotate so the scan start lands at bit 0, then take the lowest set bit.
  always_comb begin
    w_start = (last >= LW'(N-1)) ? '0 : last + LW'(1);
    w_dbl   = {req, req} >> w_start;
    w_rot   = w_dbl[N-1:0];
    any_req = |req;
    pick    = '0;
    w_sum   = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_sum = {1'b0, w_start} + (LW+1)'(k);
        pick  = (w_sum >= (LW+1)'(N)) ? LW'(w_sum - (LW+1)'(N)) : w_sum[LW-1:0];
      end
    end
  end
endmodule

// File: rtl/axis_uart_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding a single AXI-Stream UART TX,
// with an idle watchdog that revokes a grant whose source stops sending.
module axis_uart_tx_arbiter
  import axis_uart_pkg::*;
#(
  parameter int N_SRC          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [N_SRC*BYTE_W-1:0]    s_axis_tdata,
  input  logic [N_SRC-1:0]           s_axis_tvalid,
  input  logic [N_SRC-1:0]           s_axis_tlast,
  output logic [N_SRC-1:0]           s_axis_tready,
  output logic [BYTE_W-1:0]          m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [$clog2(N_SRC)-1:0]   grant_id,
  output logic                       busy,
  output logic                       timeout_pulse
);
  localparam int GW = $clog2(N_SRC);

  arb_state_t        r_state, w_next;
  logic [GW-1:0]     r_grant, r_last, w_pick;
  logic              w_any, w_sel_valid, w_sel_last, w_hs, w_pkt_end, w_expire;
  logic [BYTE_W-1:0] w_sel_data;

  rr_priority_pick #(.N(N_SRC)) u_pick (
    .req     (s_axis_tvalid),
    .last    (r_last),
    .any_req (w_any),
    .pick    (w_pick)
  );

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_grant == GW'(i)) begin
        w_sel_valid = s_axis_tvalid[i];
        w_sel_last  = s_axis_tlast[i];
        w_sel_data  = s_axis_tdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign w_hs      = (r_state == ARB_GRANT) && w_sel_valid && m_axis_tready;
  assign w_pkt_end = w_hs && w_sel_last;

  always_ff @(posedge aclk) begin
    if (areset) r_state <= ARB_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE:  if (w_any) w_next = ARB_GRANT;
      ARB_GRANT: if (w_pkt_end || w_expire) w_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    s_axis_tready = '0;
    busy          = (r_state == ARB_GRANT);
    if (r_state == ARB_GRANT) begin
      m_axis_tvalid = w_sel_valid;
      m_axis_tdata  = w_sel_data;
      for (int i = 0; i < N_SRC; i++)
        s_axis_tready[i] = m_axis_tready && (r_grant == GW'(i));
    end
  end

  // r_last marks the most recently served source; it gets lowest priority next.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_grant <= '0;
      r_last  <= GW'(N_SRC-1);
    end else if (r_state == ARB_IDLE) begin
      if (w_any) r_grant <= w_pick;
    end else if (w_pkt_end || w_expire) begin
      r_last <= r_grant;
    end
  end

  assign grant_id = r_grant;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
      localparam int CW = $clog2(TIMEOUT_CYCLES+1);
      logic [CW-1:0] r_idle_cnt;
      logic          r_tpulse;
      logic          w_stall;

      // Only a missing tvalid counts; back-pressure from the UART never does.
      assign w_stall  = (r_state == ARB_GRANT) && !w_sel_valid;
      assign w_expire = w_stall && (r_idle_cnt == CW'(TIMEOUT_CYCLES-1));

      always_ff @(posedge aclk) begin
        if (areset) begin
          r_idle_cnt <= '0;
          r_tpulse   <= 1'b0;
        end else begin
          r_tpulse <= w_expire;
          if (r_state == ARB_IDLE || w_hs)
            r_idle_cnt <= '0;
          else if (w_stall && r_idle_cnt != CW'(TIMEOUT_CYCLES))
            r_idle_cnt <= r_idle_cnt + CW'(1);
        end
      end

      assign timeout_pulse = r_tpulse;
    end else begin : g_no_wdog
      assign w_expire      = 1'b0;
      assign timeout_pulse = 1'b0;
    end
  endgenerate
endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Bench for axis_uart_tx_arbiter: queued AXIS sources, a transaction-level
// arbitration model, and directed plus random scenarios.
module tb_axis_uart_tx_arbiter;
  localparam int N = 4;
  localparam int T = 16;

  logic           aclk = 1'b0;
  logic           areset = 1'b1;
  logic [N*8-1:0] s_tdata;
  logic [N-1:0]   s_tvalid, s_tlast, s_tready;
  logic [7:0]     m_tdata;
  logic           m_tvalid, m_tready;
  logic [1:0]     grant_id;
  logic           busy, tpulse;

  always #5 aclk = ~aclk;

  axis_uart_tx_arbiter #(.N_SRC(N), .TIMEOUT_CYCLES(T)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .grant_id(grant_id), .busy(busy), .timeout_pulse(tpulse)
  );

  typedef struct { int cyc; int id; logic [7:0] d; logic last; } beat_t;

  int         tests = 0, fails = 0, cyc = 0;
  logic [8:0] src_q [N][$];
  logic [8:0] exp_q [N][$];
  logic [N-1:0] hold;
  beat_t      log_q[$];

  // Reference model: who owns the stream, who was served last, idle count.
  logic mb, mp;
  int   mg, ml, mi;

  function automatic int rr_next(int last, logic [N-1:0] req);
    for (int k = 1; k <= N; k++) if (req[(last+k)%N]) return (last+k)%N;
    return last;
  endfunction

  always @(posedge aclk) begin
    if (areset) begin
      mb <= 1'b0; mg <= 0; ml <= N-1; mi <= 0; mp <= 1'b0;
    end else begin
      mp <= 1'b0;
      if (!mb) begin
        if (s_tvalid != '0) begin mb <= 1'b1; mg <= rr_next(ml, s_tvalid); mi <= 0; end
      end else if (s_tvalid[mg]) begin
        if (m_tready) begin
          mi <= 0;
          if (s_tlast[mg]) begin mb <= 1'b0; ml <= mg; end
        end
      end else if (mi + 1 >= T) begin
        mb <= 1'b0; ml <= mg; mp <= 1'b1;
      end else begin
        mi <= mi + 1;
      end
    end
  end

  function automatic logic [16:0] exp_vec();
    logic ev; logic [7:0] ed; logic [N-1:0] er;
    ev = mb && s_tvalid[mg];
    ed = ev ? s_tdata[mg*8 +: 8] : 8'h0;
    er = mb ? (4'(m_tready) << mg) : '0;
    return {mb, 2'(mg), ev, ed, er, mp};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {busy, grant_id, m_tvalid, (m_tvalid ? m_tdata : 8'h0), s_tready, tpulse};
  endfunction

  task automatic drive_inputs();
    logic [8:0] f;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        f = src_q[i][0];
        s_tvalid[i] = 1'b1; s_tdata[i*8 +: 8] = f[7:0]; s_tlast[i] = f[8];
      end else begin
        s_tvalid[i] = 1'b0; s_tdata[i*8 +: 8] = 8'h0; s_tlast[i] = 1'b0;
      end
    end
  endtask

  // Called at the negedge: log the output beat, advance an edge, retire source beats.
  task automatic tick();
    logic [N-1:0] hs;
    beat_t bt;
    hs = s_tvalid & s_tready;
    if (m_tvalid && m_tready) begin
      bt.cyc = cyc; bt.id = int'(grant_id); bt.d = m_tdata; bt.last = s_tlast[grant_id];
      log_q.push_back(bt);
    end
    @(posedge aclk); #1;
    for (int i = 0; i < N; i++) if (hs[i]) void'(src_q[i].pop_front());
    cyc++;
    drive_inputs();
  endtask

  task automatic push_pkt(int src, int len);
    logic [8:0] b9;
    for (int b = 0; b < len; b++) begin
      b9 = {(b == len-1), 8'($urandom)};
      src_q[src].push_back(b9);
      exp_q[src].push_back(b9);
    end
    drive_inputs();
  endtask

  task automatic do_reset();
    areset = 1'b1; hold = '0; m_tready = 1'b1;
    for (int i = 0; i < N; i++) begin src_q[i].delete(); exp_q[i].delete(); end
    log_q.delete();
    drive_inputs();
    repeat (2) begin @(negedge aclk); tick(); end
    areset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    push_pkt(2, 1);
    areset = 1'b1;
    repeat (3) begin
      @(negedge aclk); tests++;
      if ({busy, grant_id, m_tvalid, s_tready, tpulse} !== 9'h0) begin
        fails++; $display("FAIL reset_state cyc=%0d got=%b exp=0", cyc, {busy, grant_id, m_tvalid, s_tready, tpulse});
      end
      tick();
    end
    areset = 1'b0;
    repeat (4) begin
      @(negedge aclk); tests++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
      tick();
    end
  endtask

  task automatic test_single_packet();
    int c0; logic [8:0] e;
    do_reset();
    c0 = cyc;
    push_pkt(1, 3);
    repeat (8) begin
      @(negedge aclk); tests++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL single cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
      tick();
    end
    tests++;
    if (log_q.size() !== 3) begin fails++; $display("FAIL single_count got=%0d exp=3", log_q.size()); end
    else for (int b = 0; b < 3; b++) begin
      e = exp_q[1][b];
      tests++;
      if (log_q[b].id !== 1 || log_q[b].d !== e[7:0] || log_q[b].cyc !== c0 + 1 + b) begin
        fails++; $display("FAIL single_beat%0d got id=%0d d=%h c=%0d exp id=1 d=%h c=%0d",
                          b, log_q[b].id, log_q[b].d, log_q[b].cyc, e[7:0], c0 + 1 + b);
      end
    end
  endtask

  task automatic test_simultaneous();
    int exp_ids[6] = '{0, 0, 2, 2, 3, 3};
    do_reset();
    push_pkt(0, 2); push_pkt(2, 2); push_pkt(3, 2);
    repeat (12) begin
      @(negedge aclk); tests++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL simult cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
      tick();
    end
    tests++;
    if (log_q.size() !== 6) begin fails++; $display("FAIL simult_count got=%0d exp=6", log_q.size()); end
    else for (int k = 0; k < 6; k++) begin
      tests++;
      if (log_q[k].id !== exp_ids[k]) begin fails++; $display("FAIL simult_order beat%0d got=%0d exp=%0d", k, log_q[k].id, exp_ids[k]); end
      if (k > 0) begin
        tests++;
        if (log_q[k].cyc - log_q[k-1].cyc !== (log_q[k-1].last ? 2 : 1)) begin
          fails++; $display("FAIL simult_gap beat%0d got=%0d exp=%0d", k, log_q[k].cyc - log_q[k-1].cyc, log_q[k-1].last ? 2 : 1);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int exp_ids[8] = '{2, 2, 0, 0, 2, 2, 0, 0};
    do_reset();
    push_pkt(2, 2); push_pkt(2, 2);
    @(negedge aclk); tests++;
    if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
    tick();
    push_pkt(0, 2); push_pkt(0, 2);
    repeat (16) begin
      @(negedge aclk); tests++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
      tick();
    end
    tests++;
    if (log_q.size() !== 8) begin fails++; $display("FAIL b2b_count got=%0d exp=8", log_q.size()); end
    else for (int k = 0; k < 8; k++) begin
      tests++;
      if (log_q[k].id !== exp_ids[k]) begin fails++; $display("FAIL b2b_order beat%0d got=%0d exp=%0d", k, log_q[k].id, exp_ids[k]); end
    end
  endtask

  task automatic test_stall();
    int n; logic [8:0] e;
    do_reset();
    push_pkt(1, 3);
    e = exp_q[1][1];
    n = 0;
    while (log_q.size() < 1 && n < 10) begin
      @(negedge aclk); tests++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL stall_pre cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
      tick(); n++;
    end
    m_tready = 1'b0;
    repeat (2000) begin
      @(negedge aclk); tests++;
      if (dut_vec() !== exp_vec() || !m_tvalid || m_tdata !== e[7:0] || tpulse) begin
        fails++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h data=%h want=%h", cyc, dut_vec(), exp_vec(), m_tdata, e[7:0]);
      end
      tick();
    end
    m_tready = 1'b1;
    repeat (6) begin
      @(negedge aclk); tests++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL stall_post cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
      tick();
    end
    tests++;
    if (log_q.size() !== 3 || log_q[1].d !== e[7:0]) begin
      fails++; $display("FAIL stall_resume got=%0d beats exp=3", log_q.size());
    end
  endtask

  task automatic test_timeout();
    int t0, tp, npulse; logic [2:0] after;
    do_reset();
    push_pkt(1, 3); push_pkt(2, 2);
    t0 = -1; tp = -1; npulse = 0; after = '0;
    repeat (40) begin
      @(negedge aclk); tests++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL timeout cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
      if (tpulse) begin npulse++; tp = cyc; end
      if (tp >= 0 && cyc == tp + 1) after = {busy, grant_id};
      tick();
      if (log_q.size() == 1 && !hold[1]) begin hold[1] = 1'b1; drive_inputs(); t0 = cyc; end
    end
    tests++;
    if (t0 < 0 || tp - t0 !== T || npulse !== 1) begin
      fails++; $display("FAIL timeout_when got=%0d pulses=%0d delay=%0d exp=1 pulse delay=%0d", npulse, npulse, tp - t0, T);
    end
    tests++;
    if (after !== 3'b110) begin fails++; $display("FAIL timeout_regrant got=%b exp=110", after); end
    tests++;
    if (log_q.size() !== 3 || log_q[1].id !== 2 || log_q[2].id !== 2) begin
      fails++; $display("FAIL timeout_src2 got=%0d beats exp=3", log_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n, k, first;
    do_reset();
    push_pkt(3, 4);
    n = 0;
    while (log_q.size() < 2 && n < 10) begin
      @(negedge aclk); tests++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL rstmid_pre cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
      tick(); n++;
    end
    areset = 1'b1;
    @(negedge aclk); tick();
    areset = 1'b0;
    k = cyc;
    push_pkt(0, 1);
    @(negedge aclk); tests++;
    if (busy !== 1'b0 || s_tready !== '0 || grant_id !== 2'd0) begin
      fails++; $display("FAIL rstmid_state got=%b%b%b exp=0 0000 00", busy, s_tready, grant_id);
    end
    tick();
    repeat (10) begin
      @(negedge aclk); tests++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL rstmid_post cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
      tick();
    end
    first = -1;
    foreach (log_q[i]) if (first < 0 && log_q[i].cyc > k) first = i;
    tests++;
    if (first < 0 || first + 1 >= log_q.size() || log_q[first].id !== 0 || log_q[first+1].id !== 3) begin
      fails++; $display("FAIL rstmid_tie got first=%0d exp src0 then src3", first < 0 ? -1 : log_q[first].id);
    end
  endtask

  task automatic test_random();
    int s, nleft; logic [8:0] e;
    do_reset();
    repeat (400) begin
      m_tready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        s = $urandom_range(0, N-1);
        if (src_q[s].size() < 6) push_pkt(s, $urandom_range(1, 4));
      end
      @(negedge aclk); tests++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
      tick();
    end
    m_tready = 1'b1;
    repeat (80) begin
      @(negedge aclk); tests++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL drain cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec()); end
      tick();
    end
    foreach (log_q[i]) begin
      tests++;
      if (exp_q[log_q[i].id].size() == 0) begin
        fails++; $display("FAIL random_sb extra byte %h from src%0d", log_q[i].d, log_q[i].id);
      end else begin
        e = exp_q[log_q[i].id].pop_front();
        if (log_q[i].d !== e[7:0]) begin fails++; $display("FAIL random_sb src%0d got=%h exp=%h", log_q[i].id, log_q[i].d, e[7:0]); end
      end
    end
    nleft = 0;
    for (int i = 0; i < N; i++) nleft += exp_q[i].size();
    tests++;
    if (nleft !== 0) begin fails++; $display("FAIL random_left got=%0d exp=0", nleft); end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_simultaneous();
    test_back_to_back();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog sim time exceeded got=timeout exp=finish");
    $fatal(1, "bench stalled");
  end
endmodule
